// File: rtl/addr4u_operand_checker.sv
// Operand checker for an external 4-bit combinational adder: registers the operands,
// waits a fixed settle time, samples the sum, compares it to a golden sum and counts mismatches.
module addr4u_operand_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    input  logic [4:0]       add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_sum,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky,
    input  logic             clr_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        OUT
    } state_e;

    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [3:0]       add_a_q, add_a_d;
    logic [3:0]       add_b_q, add_b_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [4:0]       out_sum_q, out_sum_d;
    logic             out_err_q, out_err_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_sticky_q, err_sticky_d;
    logic [4:0]       golden;
    logic             mismatch;

    assign golden   = {1'b0, add_a_q} + {1'b0, add_b_q};
    assign mismatch = (add_sum != golden);

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d      = state_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        cnt_d        = cnt_q;
        out_sum_d    = out_sum_q;
        out_err_d    = out_err_q;
        out_valid_d  = out_valid_q;
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    add_a_d = in_a;
                    add_b_d = in_b;
                    cnt_d   = SETTLE_INIT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q <= 4'd1) begin
                    out_sum_d   = add_sum;
                    out_err_d   = mismatch;
                    out_valid_d = 1'b1;
                    cnt_d       = 4'd0;
                    state_d     = OUT;
                    if (mismatch) begin
                        err_sticky_d = 1'b1;
                        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            OUT: begin
                // Returning to IDLE here means the handshake edge can never also accept.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides a mismatch sampled on the same edge.
        if (clr_cnt) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            add_a_q      <= '0;
            add_b_q      <= '0;
            cnt_q        <= '0;
            out_sum_q    <= '0;
            out_err_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            cnt_q        <= cnt_d;
            out_sum_q    <= out_sum_d;
            out_err_q    <= out_err_d;
            out_valid_q  <= out_valid_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign in_ready   = (state_q == IDLE) && rst_n;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign out_valid  = out_valid_q;
    assign out_sum    = out_sum_q;
    assign out_err    = out_err_q;
    assign err_cnt    = err_cnt_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_addr4u_operand_checker.sv
// Self-checking bench: three checker instances (settle 1, 2, 4; 2-bit counter) with a
// behavioural adder that can be forced to a wrong value, directed vectors, random and sweep.
module tb_addr4u_operand_checker;

    localparam int N_DUT   = 3;
    localparam int CNT_MAX = 3;

    logic       clk;
    logic       rst_n     [N_DUT];
    logic       in_valid  [N_DUT];
    logic       in_ready  [N_DUT];
    logic [3:0] in_a      [N_DUT];
    logic [3:0] in_b      [N_DUT];
    logic [3:0] add_a     [N_DUT];
    logic [3:0] add_b     [N_DUT];
    logic [4:0] add_sum   [N_DUT];
    logic       out_valid [N_DUT];
    logic       out_ready [N_DUT];
    logic [4:0] out_sum   [N_DUT];
    logic       out_err   [N_DUT];
    logic [1:0] err_cnt   [N_DUT];
    logic       err_sticky[N_DUT];
    logic       clr_cnt   [N_DUT];
    logic       force_en  [N_DUT];
    logic [4:0] force_val [N_DUT];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference counter state per instance.
    int exp_cnt [N_DUT];
    int exp_st  [N_DUT];

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        addr4u_operand_checker #(
            .SETTLE_CYCLES(g == 0 ? 1 : (g == 1 ? 2 : 4)),
            .CNT_W        (2)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_a      (in_a[g]),
            .in_b      (in_b[g]),
            .add_a     (add_a[g]),
            .add_b     (add_b[g]),
            .add_sum   (add_sum[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_sum   (out_sum[g]),
            .out_err   (out_err[g]),
            .err_cnt   (err_cnt[g]),
            .err_sticky(err_sticky[g]),
            .clr_cnt   (clr_cnt[g])
        );
        assign add_sum[g] = force_en[g] ? force_val[g] : ({1'b0, add_a[g]} + {1'b0, add_b[g]});
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // One transaction, starting and ending on a falling edge with the instance idle.
    task automatic run_txn(input int k, input logic [3:0] a, input logic [3:0] b,
                           input logic fen, input logic [4:0] fval, input logic clr,
                           input int hold, output logic [4:0] gsum, output logic gerr);
        int         golden;
        int         exp_sum;
        int         exp_err;
        int         lat;
        golden  = int'(a) + int'(b);
        exp_sum = fen ? int'(fval) : golden;
        exp_err = (exp_sum != golden) ? 1 : 0;

        check("in_ready_idle", int'(in_ready[k]), 1);
        in_valid[k]  = 1'b1;
        in_a[k]      = a;
        in_b[k]      = b;
        force_en[k]  = fen;
        force_val[k] = fval;
        clr_cnt[k]   = clr;
        @(negedge clk);
        in_a[k] = ~a;
        in_b[k] = ~b;
        check("add_a_loaded", int'(add_a[k]), int'(a));
        check("add_b_loaded", int'(add_b[k]), int'(b));

        lat = 0;
        in_valid[k] = 1'($urandom_range(0, 1));
        while (!out_valid[k] && lat < 40) begin
            @(negedge clk);
            lat++;
            in_valid[k] = 1'($urandom_range(0, 1));
        end
        clr_cnt[k] = 1'b0;

        if (clr) begin
            exp_cnt[k] = 0;
            exp_st[k]  = 0;
        end else if (exp_err != 0) begin
            exp_cnt[k] = (exp_cnt[k] < CNT_MAX) ? exp_cnt[k] + 1 : CNT_MAX;
            exp_st[k]  = 1;
        end

        check("out_valid_seen", int'(out_valid[k]), 1);
        check("latency", lat, settle_of(k));
        check("out_sum", int'(out_sum[k]), exp_sum);
        check("out_err", int'(out_err[k]), exp_err);
        check("err_cnt", int'(err_cnt[k]), exp_cnt[k]);
        check("err_sticky", int'(err_sticky[k]), exp_st[k]);
        gsum = out_sum[k];
        gerr = out_err[k];

        for (int h = 0; h < hold; h++) begin
            in_valid[k]  = ~in_valid[k];
            out_ready[k] = 1'b0;
            @(negedge clk);
            check("hold_out_valid", int'(out_valid[k]), 1);
            check("hold_out_sum", int'(out_sum[k]), exp_sum);
            check("hold_out_err", int'(out_err[k]), exp_err);
            check("hold_in_ready", int'(in_ready[k]), 0);
            check("hold_add_a", int'(add_a[k]), int'(a));
            check("hold_add_b", int'(add_b[k]), int'(b));
        end

        in_valid[k]  = 1'b1;
        out_ready[k] = 1'b1;
        @(negedge clk);
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        force_en[k]  = 1'b0;
        check("hs_out_valid_low", int'(out_valid[k]), 0);
        check("hs_in_ready", int'(in_ready[k]), 1);
        check("hs_no_accept_a", int'(add_a[k]), int'(a));
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       fen;
        logic [4:0] fval;
        logic       clr;
        logic [4:0] exp_sum;
        logic       exp_err;
        logic [1:0] exp_cnt;
        logic       exp_st;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [4:0] gsum;
        logic       gerr;

        vecs[0] = '{4'hF, 4'h1, 1'b0, 5'h00, 1'b0, 5'h10, 1'b0, 2'd0, 1'b0};
        vecs[1] = '{4'h3, 4'h5, 1'b1, 5'h09, 1'b0, 5'h09, 1'b1, 2'd1, 1'b1};
        vecs[2] = '{4'h2, 4'h2, 1'b1, 5'h1F, 1'b0, 5'h1F, 1'b1, 2'd2, 1'b1};
        vecs[3] = '{4'hA, 4'h6, 1'b1, 5'h00, 1'b0, 5'h00, 1'b1, 2'd3, 1'b1};
        vecs[4] = '{4'h0, 4'h0, 1'b1, 5'h01, 1'b0, 5'h01, 1'b1, 2'd3, 1'b1};
        vecs[5] = '{4'h8, 4'h8, 1'b1, 5'h0F, 1'b0, 5'h0F, 1'b1, 2'd3, 1'b1};
        vecs[6] = '{4'h9, 4'h4, 1'b1, 5'h0C, 1'b1, 5'h0C, 1'b1, 2'd0, 1'b0};
        vecs[7] = '{4'h7, 4'h7, 1'b0, 5'h00, 1'b0, 5'h0E, 1'b0, 2'd0, 1'b0};

        for (int k = 0; k < N_DUT; k++) begin
            rst_n[k]     = 1'b0;
            in_valid[k]  = 1'b0;
            in_a[k]      = 4'h0;
            in_b[k]      = 4'h0;
            out_ready[k] = 1'b0;
            clr_cnt[k]   = 1'b0;
            force_en[k]  = 1'b0;
            force_val[k] = 5'h00;
            exp_cnt[k]   = 0;
            exp_st[k]    = 0;
        end

        repeat (2) @(negedge clk);
        for (int k = 0; k < N_DUT; k++) begin
            check("rst_in_ready", int'(in_ready[k]), 0);
            check("rst_add_a", int'(add_a[k]), 0);
            check("rst_add_b", int'(add_b[k]), 0);
            check("rst_out_valid", int'(out_valid[k]), 0);
            check("rst_out_sum", int'(out_sum[k]), 0);
            check("rst_out_err", int'(out_err[k]), 0);
            check("rst_err_cnt", int'(err_cnt[k]), 0);
            check("rst_err_sticky", int'(err_sticky[k]), 0);
            rst_n[k] = 1'b1;
        end
        #1;
        for (int k = 0; k < N_DUT; k++) check("post_rst_in_ready", int'(in_ready[k]), 1);
        @(negedge clk);

        // Directed vectors, including counter saturation and clear-wins.
        for (int i = 0; i < 8; i++) begin
            run_txn(1, vecs[i].a, vecs[i].b, vecs[i].fen, vecs[i].fval, vecs[i].clr, 0, gsum, gerr);
            check("vec_out_sum", int'(gsum), int'(vecs[i].exp_sum));
            check("vec_out_err", int'(gerr), int'(vecs[i].exp_err));
            check("vec_err_cnt", int'(err_cnt[1]), int'(vecs[i].exp_cnt));
            check("vec_err_sticky", int'(err_sticky[1]), int'(vecs[i].exp_st));
        end

        // Output held for five cycles with in_valid toggling.
        run_txn(1, 4'h5, 4'hC, 1'b0, 5'h00, 1'b0, 5, gsum, gerr);

        // Reset in the middle of SETTLE discards the transaction.
        in_valid[2] = 1'b1;
        in_a[2]     = 4'h3;
        in_b[2]     = 4'h3;
        @(negedge clk);
        in_valid[2] = 1'b0;
        @(negedge clk);
        #2 rst_n[2] = 1'b0;
        #1;
        check("mid_rst_add_a", int'(add_a[2]), 0);
        check("mid_rst_add_b", int'(add_b[2]), 0);
        check("mid_rst_out_valid", int'(out_valid[2]), 0);
        check("mid_rst_out_sum", int'(out_sum[2]), 0);
        check("mid_rst_in_ready", int'(in_ready[2]), 0);
        exp_cnt[2] = 0;
        exp_st[2]  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_rst_no_pulse", int'(out_valid[2]), 0);
            if (i == 3) rst_n[2] = 1'b1;
        end
        run_txn(2, 4'h7, 4'h9, 1'b0, 5'h00, 1'b0, 0, gsum, gerr);
        check("post_rst_sum", int'(gsum), 5'h10);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            run_txn(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3), gsum, gerr);
        end

        // Full operand sweep with a correct adder on every settle setting.
        for (int k = 0; k < N_DUT; k++) begin
            for (int v = 0; v < 256; v++) begin
                run_txn(k, 4'(v >> 4), 4'(v), 1'b0, 5'h00, 1'b0, 0, gsum, gerr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/addr4u_operand_checker.md
ADDR4U_OPERAND_CHECKER -- requirements
Module: addr4u_operand_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: number of cycles the adder operands are held stable before the sum is sampled; legal range 1..15.
REQ-002 Parameter CNT_W, default 8: width of the mismatch counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  block accepts an operand pair this cycle.
REQ-007 in_a  input  4  operand A, unsigned.
REQ-008 in_b  input  4  operand B, unsigned.
REQ-009 add_a  output  4  registered operand A driven to the downstream combinational 4-bit adder.
REQ-010 add_b  output  4  registered operand B driven to the adder.
REQ-011 add_sum  input  5  adder result {carry, sum[3:0]}, combinational from add_a/add_b.
REQ-012 out_valid  output  1  checked result available.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_sum  output  5  sampled add_sum.
REQ-015 out_err  output  1  sampled add_sum differs from the golden add_a+add_b.
REQ-016 err_cnt  output  CNT_W  count of mismatching transactions, saturating.
REQ-017 err_sticky  output  1  set on any mismatch; held until cleared.
REQ-018 clr_cnt  input  1  synchronous clear of err_cnt and err_sticky.

Function
REQ-019 The FSM SHALL have three states: IDLE, SETTLE and OUT.
REQ-020 in_ready SHALL be 1 only in IDLE and only while rst_n is high.
REQ-021 In IDLE, in_valid&in_ready at an edge SHALL load in_a/in_b into add_a/add_b, load the settle counter with SETTLE_CYCLES, and move to SETTLE.
REQ-022 add_a/add_b SHALL change only on acceptance and SHALL hold through SETTLE and OUT.
REQ-023 SETTLE SHALL last exactly SETTLE_CYCLES cycles: counter decrements each edge; the edge on which it equals 1 ends the state.
REQ-024 On the edge ending SETTLE, the block SHALL register out_sum=add_sum and out_err=(add_sum != {1'b0,add_a}+{1'b0,add_b}) as a 5-bit compare, assert out_valid and move to OUT.
REQ-025 Latency: out_valid SHALL be high in the cycle following the SETTLE_CYCLES-th edge after the acceptance edge.
REQ-026 In OUT, out_valid, out_sum and out_err SHALL hold until out_valid&out_ready; on that edge the block SHALL drop out_valid and return to IDLE.
REQ-027 A new operand SHALL NOT be accepted in the same edge as an output handshake; minimum period is SETTLE_CYCLES+2 cycles.
REQ-028 On the sampling edge with mismatch, err_cnt SHALL increment by 1, saturating at 2^CNT_W-1, and err_sticky SHALL set.
REQ-029 clr_cnt high at an edge SHALL zero err_cnt and err_sticky; when it coincides with a mismatch sample, clear SHALL win, giving 0 and 0, while out_err still reports the mismatch.
REQ-030 in_valid outside IDLE, and out_ready outside OUT, SHALL be ignored.

Reset
REQ-031 rst_n low SHALL immediately force the state to IDLE and zero add_a, add_b, out_sum, out_err, out_valid, err_cnt, err_sticky and the settle counter.
REQ-032 A transaction in flight at reset SHALL be discarded with no output produced; the first edge with rst_n high SHALL be able to accept a new operand.

Verification
REQ-033 Reset, then accept in_a=4'hF, in_b=4'h1 with add_sum a correct model -> after 2 edges, out_valid=1, out_sum=5'h10, out_err=0, err_cnt=0.
REQ-034 Accept A=3, B=5 with add_sum forced to 5'h09 -> out_sum=5'h09, out_err=1, err_cnt=1, err_sticky=1.
REQ-035 Hold out_ready=0 for 5 cycles in OUT while toggling in_valid -> out_* stable, in_ready=0, add_a/add_b unchanged; then out_ready=1 -> IDLE the next cycle.
REQ-036 With CNT_W=2, force mismatches on 5 transactions -> err_cnt sequence 1,2,3,3,3; clr_cnt on a 6th mismatching sample -> err_cnt=0, err_sticky=0, out_err=1.
REQ-037 Assert rst_n low mid-SETTLE -> all outputs zero asynchronously, no out_valid pulse; after release, A=7, B=9 -> out_sum=5'h10.
REQ-038 Sweep all 256 A/B pairs with a correct adder model and SETTLE_CYCLES in {1,2,4} -> out_err always 0, measured latency equals SETTLE_CYCLES.
